instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Write side of the instruction memory that the single-cycle core reads through PC -> readAddress.
//  Accepts a byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
//  Writes those words to consecutive 5-bit word addresses starting at 0.
//  Holds the core stalled (cpu_hold) until the whole program is written, then releases it.
// PARAMETERS
//  ADDR_W      5   instruction-memory word-address width (matches PC width)
//  DATA_W      32  instruction word width
//  NUM_WORDS   32  max program length in words (2**ADDR_W)
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  rst         in   1       synchronous, active-high reset
//  start       in   1       begin a load; sampled only in IDLE, DONE, ERR
//  byte_in     in   8       stream byte
//  byte_valid  in   1       byte_in valid; source holds byte until accepted
//  byte_ready  out  1       loader can accept byte this cycle
//  wr_en       out  1       instruction-memory write strobe, one cycle per word
//  wr_addr     out  ADDR_W  word address for write
//  wr_data     out  DATA_W  assembled instruction word
//  cpu_hold    out  1       1 = core PC frozen / core held
//  done        out  1       program fully written
//  error       out  1       illegal length byte received
//  word_count  out  6       words written so far in current load
// BEHAVIOUR
//  - Reset: state=IDLE. Outputs: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0,
//    error=0, word_count=0. Reset mid-load aborts immediately and discards the partial word.
//    Words already written are not rewritten.
//  - Transfer: a byte is accepted only when byte_valid & byte_ready. byte_valid while byte_ready=0 is ignored.
//  - FSM states: IDLE, LEN, BYTES, WRITE, DONE, ERR.
//    IDLE : byte_ready=0. start -> LEN.
//    LEN  : byte_ready=1. The accepted byte is N, the program length in words.
//           N==0 or N>NUM_WORDS -> ERR. Otherwise latch N, clear byte_idx and word_count -> BYTES.
//    BYTES: byte_ready=1. Each accepted byte does shift={shift[23:0],byte_in} (big-endian: first byte = [31:24])
//           and byte_idx++. When the 4th byte (byte_idx==3) is accepted -> WRITE.
//    WRITE: byte_ready=0. wr_en=1 for exactly this cycle, wr_addr=word_count[4:0], wr_data=shift.
//           Next edge: word_count++. If word_count+1==N -> DONE, else -> BYTES with byte_idx=0.
//    DONE : done=1, cpu_hold=0, byte_ready=0. start -> LEN with done=0, cpu_hold=1.
//    ERR  : error=1, cpu_hold=1, byte_ready=0. start -> LEN with error=0.
//  - start asserted in LEN, BYTES or WRITE is ignored.
//  - Outputs are registered.
//  - Latency: the 4th byte of a word is accepted at edge T. wr_en is high in cycle T+1.
//    For the last word, done=1 and cpu_hold=0 in cycle T+2.
//  - wr_addr never wraps: N<=NUM_WORDS guarantees the max address is NUM_WORDS-1.
//  - Bytes beyond the 4*N payload are not accepted (byte_ready=0 in DONE).
// STRUCTURE
//  - Shared package/include (loader_defs): state encodings (3-bit localparams), NUM_WORDS,
//    BYTES_PER_WORD=4, length-byte legality check.
//  - Sub-module byte_packer: 32-bit shift register + 2-bit byte_idx.
//    Ports: clk, rst, clr, push, byte_in, word_out, last (byte_idx==3 & push).
//  - Top: FSM, word_count, N register, output registers.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> cpu_hold=1, done=0, error=0, wr_en=0, byte_ready=0, word_count=0.
//  2. Single word: start, bytes 01,20,08,00,05 -> one wr_en, wr_addr=0, wr_data=32'h20080005.
//     Then done=1 and cpu_hold=0 two cycles after the last byte.
//  3. Full program: N=32, 128 bytes, byte_valid toggling randomly ->
//     wr_addr 0..31 once each, word_count=32, done=1, no extra writes.
//  4. Bad length: start, byte 00 -> error=1, cpu_hold=1, no wr_en.
//     Repeat with byte 21 (N=33) -> error=1. Then start with a valid stream -> error clears, load succeeds.
//  5. Reset mid-load: N=3, 6 bytes sent, then rst ->
//     exactly one write (addr 0), state IDLE, word_count=0, partial word not written.
//  6. Reload: after DONE, start and send N=1, word 8C010004 ->
//     cpu_hold=1 during load, wr_addr=0, wr_data=32'h8C010004, done re-asserts.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: geometry, FSM encoding
// and the length-byte legality check.
package instr_mem_loader_pkg;

  localparam int ADDR_W         = 5;
  localparam int DATA_W         = 32;
  localparam int NUM_WORDS      = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_BYTES = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // A program must hold at least one word and fit in the memory.
  function automatic logic len_ok(input logic [7:0] n, input int max_words);
    return (n != 8'd0) && (int'(n) <= max_words);
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte pushed ends up in the top byte.
module byte_packer
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA_W = instr_mem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              last
);

  logic [1:0] byte_idx;

  assign last = push && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word_out <= '0;
      byte_idx <= '0;
    end else if (push) begin
      word_out <= {word_out[DATA_W-9:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed byte program into instruction memory and keeps the
// core held until every word has been written.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = instr_mem_loader_pkg::ADDR_W,
  parameter int DATA_W    = instr_mem_loader_pkg::DATA_W,
  parameter int NUM_WORDS = instr_mem_loader_pkg::NUM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [5:0]        word_count
);

  state_e     state;
  logic [5:0] n_len;
  logic       accept, pk_clr, pk_push, pk_last;
  logic [5:0] wcount_nxt;

  assign accept     = byte_valid && byte_ready;
  assign pk_clr     = (state == S_LEN) && accept;
  assign pk_push    = (state == S_BYTES) && accept;
  assign wcount_nxt = word_count + 6'd1;

  // The packer's register doubles as the write-data output register.
  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .push     (pk_push),
    .byte_in  (byte_in),
    .word_out (wr_data),
    .last     (pk_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      n_len      <= '0;
      byte_ready <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state      <= S_LEN;
          byte_ready <= 1'b1;
        end
        S_LEN: if (accept) begin
          if (len_ok(byte_in, NUM_WORDS)) begin
            n_len      <= byte_in[5:0];
            word_count <= '0;
            state      <= S_BYTES;
          end else begin
            error      <= 1'b1;
            byte_ready <= 1'b0;
            state      <= S_ERR;
          end
        end
        S_BYTES: if (pk_last) begin
          byte_ready <= 1'b0;
          wr_en      <= 1'b1;
          wr_addr    <= word_count[ADDR_W-1:0];
          state      <= S_WRITE;
        end
        S_WRITE: begin
          wr_en      <= 1'b0;
          word_count <= wcount_nxt;
          if (wcount_nxt == n_len) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= S_DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= S_BYTES;
          end
        end
        S_DONE: if (start) begin
          done       <= 1'b0;
          cpu_hold   <= 1'b1;
          byte_ready <= 1'b1;
          state      <= S_LEN;
        end
        S_ERR: if (start) begin
          error      <= 1'b0;
          byte_ready <= 1'b1;
          state      <= S_LEN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
